// File: rtl/papilio_wb_fifo_periph.sv
// Wishbone slave peripheral with CONTROL/STATUS/DATA/LEVEL registers, a TX FIFO
// drained by a valid/ready stream and an RX FIFO filled from a valid/ready stream.
module papilio_wb_fifo_periph #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    output logic                  wb_ack_o,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    input  logic [DATA_WIDTH-1:0] rx_data_i,
    input  logic                  rx_valid_i,
    output logic                  rx_ready_o,
    output logic                  irq_o
);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int RX_LVL_W = DATA_WIDTH / 2;
    localparam int TX_LVL_W = DATA_WIDTH - RX_LVL_W;
    localparam int TX       = 0;
    localparam int RX       = 1;

    typedef enum logic [1:0] {
        REG_CONTROL = 2'd0,
        REG_STATUS  = 2'd1,
        REG_DATA    = 2'd2,
        REG_LEVEL   = 2'd3
    } reg_sel_t;

    logic                  ack_reg;
    logic [DATA_WIDTH-1:0] dat_reg;
    logic [DATA_WIDTH-1:0] rd_data_next;
    logic                  en_reg, tx_ie_reg, rx_ie_reg, ovf_reg;
    logic                  en_next, tx_ie_next, rx_ie_next, ovf_next;

    logic     accept;
    logic     bus_wr;
    logic     bus_rd;
    logic     soft_rst;
    reg_sel_t sel;
    logic     unused_adr;

    // The ack itself blocks re-acceptance, so a strobe held through the ack
    // cycle produces exactly one transfer.
    assign accept     = wb_cyc_i & wb_stb_i & ~ack_reg;
    assign bus_wr     = accept & wb_we_i;
    assign bus_rd     = accept & ~wb_we_i;
    assign sel        = reg_sel_t'(wb_adr_i[3:2]);
    assign soft_rst   = bus_wr && (sel == REG_CONTROL) && wb_dat_i[1];
    assign unused_adr = ^wb_adr_i;

    logic [1:0]                 fifo_push;
    logic [1:0]                 fifo_pop;
    logic [1:0]                 fifo_full;
    logic [1:0]                 fifo_empty;
    logic [1:0][DATA_WIDTH-1:0] fifo_din;
    logic [1:0][DATA_WIDTH-1:0] fifo_head;
    logic [1:0][CNT_W-1:0]      fifo_count;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
            logic [CNT_W-1:0]      wr_ptr_reg;
            logic [CNT_W-1:0]      rd_ptr_reg;

            always_ff @(posedge clk) begin
                if (rst || soft_rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                end else begin
                    if (fifo_push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (fifo_pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (fifo_push[gi]) mem[wr_ptr_reg[PTR_W-1:0]] <= fifo_din[gi];
            end

            // Head is read combinationally so the TX stream is first-word fall-through.
            assign fifo_head[gi]  = mem[rd_ptr_reg[PTR_W-1:0]];
            assign fifo_count[gi] = wr_ptr_reg - rd_ptr_reg;
            assign fifo_empty[gi] = (wr_ptr_reg == rd_ptr_reg);
            assign fifo_full[gi]  = (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]) &&
                                    (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]);
        end
    endgenerate

    assign fifo_din[TX]  = wb_dat_i;
    assign fifo_din[RX]  = rx_data_i;
    assign tx_data_o     = fifo_head[TX];
    assign tx_valid_o    = en_reg & ~fifo_empty[TX];
    assign rx_ready_o    = en_reg & ~fifo_full[RX];

    // No bypass at full: a TX push is judged against the pre-edge fill level.
    assign fifo_push[TX] = bus_wr && (sel == REG_DATA) && en_reg && !fifo_full[TX];
    assign fifo_pop[TX]  = tx_valid_o & tx_ready_i;
    assign fifo_push[RX] = rx_valid_i & rx_ready_o;
    assign fifo_pop[RX]  = bus_rd && (sel == REG_DATA) && !fifo_empty[RX];

    logic [RX_LVL_W-1:0] rx_level;
    logic [TX_LVL_W-1:0] tx_level;

    always_comb begin
        rx_level = RX_LVL_W'(fifo_count[RX]);
        tx_level = TX_LVL_W'(fifo_count[TX]);
        if ((fifo_count[RX] >> RX_LVL_W) != '0) rx_level = '1;
        if ((fifo_count[TX] >> TX_LVL_W) != '0) tx_level = '1;
    end

    always_comb begin
        rd_data_next = '0;
        case (sel)
            REG_CONTROL: begin
                rd_data_next[0] = en_reg;
                rd_data_next[2] = tx_ie_reg;
                rd_data_next[3] = rx_ie_reg;
            end
            REG_STATUS: begin
                rd_data_next[0] = en_reg;
                rd_data_next[1] = fifo_full[TX];
                rd_data_next[2] = fifo_empty[TX];
                rd_data_next[3] = fifo_empty[RX];
                rd_data_next[4] = fifo_full[RX];
                rd_data_next[5] = ovf_reg;
            end
            REG_DATA: begin
                if (!fifo_empty[RX]) rd_data_next = fifo_head[RX];
            end
            REG_LEVEL: begin
                rd_data_next = {tx_level, rx_level};
            end
        endcase
    end

    // A new overflow at the same edge as a W1C wins; soft reset beats both.
    always_comb begin
        en_next    = en_reg;
        tx_ie_next = tx_ie_reg;
        rx_ie_next = rx_ie_reg;
        ovf_next   = ovf_reg;
        if (bus_wr && (sel == REG_STATUS) && wb_dat_i[5]) ovf_next = 1'b0;
        if (rx_valid_i && en_reg && fifo_full[RX]) ovf_next = 1'b1;
        if (bus_wr && (sel == REG_CONTROL)) begin
            en_next    = wb_dat_i[0];
            tx_ie_next = wb_dat_i[2];
            rx_ie_next = wb_dat_i[3];
        end
        if (soft_rst) begin
            en_next    = 1'b0;
            tx_ie_next = 1'b0;
            rx_ie_next = 1'b0;
            ovf_next   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_reg   <= 1'b0;
            dat_reg   <= '0;
            en_reg    <= 1'b0;
            tx_ie_reg <= 1'b0;
            rx_ie_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            ack_reg   <= accept;
            if (bus_rd) dat_reg <= rd_data_next;
            en_reg    <= en_next;
            tx_ie_reg <= tx_ie_next;
            rx_ie_reg <= rx_ie_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign wb_ack_o = ack_reg;
    assign wb_dat_o = dat_reg;
    assign irq_o    = (tx_ie_reg & fifo_empty[TX]) | (rx_ie_reg & ~fifo_empty[RX]) | ovf_reg;

endmodule

// File: tb/tb_papilio_wb_fifo_periph.sv
// Self-checking bench: directed register table, multi-cycle corner sequences and
// randomized traffic checked every cycle against a queue-based reference model.
module tb_papilio_wb_fifo_periph;
    localparam int DW    = 8;
    localparam int AW    = 16;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] wb_adr_i = '0;
    logic [DW-1:0] wb_dat_i = '0;
    logic [DW-1:0] wb_dat_o;
    logic          wb_we_i = 1'b0;
    logic          wb_cyc_i = 1'b0;
    logic          wb_stb_i = 1'b0;
    logic          wb_ack_o;
    logic [DW-1:0] tx_data_o;
    logic          tx_valid_o;
    logic          tx_ready_i = 1'b0;
    logic [DW-1:0] rx_data_i = '0;
    logic          rx_valid_i = 1'b0;
    logic          rx_ready_o;
    logic          irq_o;

    papilio_wb_fifo_periph #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_ack_o(wb_ack_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain queues and flags derived from the register-map rules.
    bit          m_en, m_txie, m_rxie, m_ovf, m_ack;
    logic [7:0]  m_dat;
    logic [7:0]  m_tx[$];
    logic [7:0]  m_rx[$];

    function automatic int sat15(input int n);
        return (n > 15) ? 15 : n;
    endfunction

    task automatic model_reset();
        m_en = 0; m_txie = 0; m_rxie = 0; m_ovf = 0; m_ack = 0; m_dat = '0;
        m_tx.delete();
        m_rx.delete();
    endtask

    task automatic model_step();
        int ntx, nrx;
        bit tx_pop, rx_push, ovf_set, acc, flush, ovf_clr, tx_push, rx_pop, ctrl_wr;
        logic [7:0] rd;
        logic [1:0] sel;
        if (rst) begin
            model_reset();
        end else begin
            ntx = m_tx.size();
            nrx = m_rx.size();
            tx_pop  = m_en && ntx > 0 && tx_ready_i;
            rx_push = rx_valid_i && m_en && nrx < DEPTH;
            ovf_set = rx_valid_i && m_en && nrx == DEPTH;
            acc = wb_cyc_i && wb_stb_i && !m_ack;
            sel = wb_adr_i[3:2];
            flush = 0; ovf_clr = 0; tx_push = 0; rx_pop = 0; ctrl_wr = 0;
            if (acc && wb_we_i) begin
                if (sel == 2'd0) begin
                    if (wb_dat_i[1]) flush = 1; else ctrl_wr = 1;
                end
                if (sel == 2'd1) ovf_clr = wb_dat_i[5];
                if (sel == 2'd2) tx_push = m_en && ntx < DEPTH;
            end
            if (acc && !wb_we_i) begin
                rd = '0;
                case (sel)
                    2'd0: rd = {4'b0, m_rxie, m_txie, 1'b0, m_en};
                    2'd1: rd = {2'b0, m_ovf, nrx == DEPTH, nrx == 0, ntx == 0, ntx == DEPTH, m_en};
                    2'd2: begin
                        if (nrx > 0) begin rd = m_rx[0]; rx_pop = 1; end
                    end
                    default: rd = {4'(sat15(ntx)), 4'(sat15(nrx))};
                endcase
                m_dat = rd;
            end
            m_ack = acc;
            if (tx_pop)  void'(m_tx.pop_front());
            if (tx_push) m_tx.push_back(wb_dat_i);
            if (rx_pop)  void'(m_rx.pop_front());
            if (rx_push) m_rx.push_back(rx_data_i);
            m_ovf = (m_ovf && !ovf_clr) || ovf_set;
            if (ctrl_wr) begin
                m_en = wb_dat_i[0]; m_txie = wb_dat_i[2]; m_rxie = wb_dat_i[3];
            end
            if (flush) begin
                m_en = 0; m_txie = 0; m_rxie = 0; m_ovf = 0;
                m_tx.delete();
                m_rx.delete();
            end
        end
    endtask

    task automatic check_outputs();
        bit exp_tv;
        exp_tv = m_en && m_tx.size() > 0;
        chk("ack", wb_ack_o, m_ack);
        chk("rdata", wb_dat_o, m_dat);
        chk("tx_valid", tx_valid_o, exp_tv);
        if (exp_tv) chk("tx_data", tx_data_o, m_tx[0]);
        chk("rx_ready", rx_ready_o, m_en && m_rx.size() < DEPTH);
        chk("irq", irq_o, (m_txie && m_tx.size() == 0) || (m_rxie && m_rx.size() > 0) || m_ovf);
    endtask

    logic       s_rst = 1'b1;
    logic       s_trdy = 1'b0;
    logic       s_rvld = 1'b0;
    logic [7:0] s_rdat = '0;

    task automatic step(input logic act, input logic [3:0] adr, input logic we, input logic [7:0] dat);
        @(negedge clk);
        rst = s_rst;
        wb_cyc_i = act; wb_stb_i = act;
        wb_adr_i = {12'h000, adr}; wb_we_i = we; wb_dat_i = dat;
        tx_ready_i = s_trdy; rx_valid_i = s_rvld; rx_data_i = s_rdat;
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic wb_write(input logic [3:0] adr, input logic [7:0] dat);
        step(1'b1, adr, 1'b1, dat);
        step(1'b0, 4'h0, 1'b0, 8'h00);
    endtask

    task automatic wb_read(input logic [3:0] adr, output logic [7:0] d);
        step(1'b1, adr, 1'b0, 8'h00);
        d = wb_dat_o;
        step(1'b0, 4'h0, 1'b0, 8'h00);
    endtask

    task automatic idle();
        step(1'b0, 4'h0, 1'b0, 8'h00);
    endtask

    typedef struct {
        logic [3:0] adr;
        logic       we;
        logic [7:0] dat;
        logic [7:0] exp;
    } vec_t;

    vec_t       tbl[13];
    logic [7:0] d;
    logic [7:0] exp3[3] = '{8'h11, 8'h22, 8'h33};

    initial begin
        tbl[0]  = '{4'h0, 1'b0, 8'h00, 8'h00};
        tbl[1]  = '{4'h4, 1'b0, 8'h00, 8'h0C};
        tbl[2]  = '{4'h8, 1'b0, 8'h00, 8'h00};
        tbl[3]  = '{4'hC, 1'b0, 8'h00, 8'h00};
        tbl[4]  = '{4'h0, 1'b1, 8'h01, 8'h00};
        tbl[5]  = '{4'h8, 1'b1, 8'h11, 8'h00};
        tbl[6]  = '{4'h8, 1'b1, 8'h22, 8'h00};
        tbl[7]  = '{4'h8, 1'b1, 8'h33, 8'h00};
        tbl[8]  = '{4'hC, 1'b0, 8'h00, 8'h30};
        tbl[9]  = '{4'h4, 1'b0, 8'h00, 8'h09};
        tbl[10] = '{4'h0, 1'b0, 8'h00, 8'h01};
        tbl[11] = '{4'hC, 1'b1, 8'hFF, 8'h00};
        tbl[12] = '{4'hC, 1'b0, 8'h00, 8'h30};

        model_reset();
        idle();
        idle();
        s_rst = 1'b0;
        chk("reset_ack", wb_ack_o, 0);
        chk("reset_irq", irq_o, 0);

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].we) wb_write(tbl[i].adr, tbl[i].dat);
            else begin
                wb_read(tbl[i].adr, d);
                chk($sformatf("table[%0d]", i), d, tbl[i].exp);
            end
        end

        chk("fwft_valid", tx_valid_o, 1);
        chk("fwft_data", tx_data_o, 8'h11);
        s_trdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("tx_drain3", tx_data_o, exp3[i]);
            idle();
        end
        s_trdy = 1'b0;
        chk("tx_drained", tx_valid_o, 0);

        // TX overfill, drain, then refill across the pointer wrap
        for (int i = 0; i < 17; i++) wb_write(4'h8, 8'(i));
        wb_read(4'h4, d);
        chk("tx_full_status", d, 8'h0B);
        wb_read(4'hC, d);
        chk("tx_level_sat", d, 8'hF0);
        s_trdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("tx_order", tx_data_o, 8'(i));
            idle();
        end
        s_trdy = 1'b0;
        for (int i = 0; i < 5; i++) wb_write(4'h8, 8'(8'h40 + i));
        wb_read(4'hC, d);
        chk("tx_wrap_level", d, 8'h50);
        s_trdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("tx_wrap_order", tx_data_o, 8'(8'h40 + i));
            idle();
        end
        s_trdy = 1'b0;

        // RX fill to full, overflow, drain, empty read, OVF clear
        wb_write(4'h0, 8'h09);
        s_rvld = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_rdat = 8'(8'hA0 + i);
            idle();
        end
        chk("rx_full_ready", rx_ready_o, 0);
        s_rdat = 8'hEE;
        idle();
        s_rvld = 1'b0;
        chk("ovf_irq", irq_o, 1);
        wb_read(4'h4, d);
        chk("ovf_status", d, 8'h35);
        for (int i = 0; i < 16; i++) begin
            wb_read(4'h8, d);
            chk("rx_order", d, 8'(8'hA0 + i));
        end
        wb_read(4'h8, d);
        chk("rx_empty_read", d, 8'h00);
        wb_write(4'h4, 8'h20);
        chk("ovf_clear_irq", irq_o, 0);

        // Same-edge RX push + bus pop, same-edge TX push + stream pop
        s_rvld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_rdat = 8'(8'hB0 + i);
            idle();
        end
        s_rdat = 8'hB3;
        step(1'b1, 4'h8, 1'b0, 8'h00);
        s_rvld = 1'b0;
        chk("rx_same_edge_data", wb_dat_o, 8'hB0);
        idle();
        wb_write(4'h8, 8'h51);
        wb_write(4'h8, 8'h52);
        s_trdy = 1'b1;
        step(1'b1, 4'h8, 1'b1, 8'h53);
        s_trdy = 1'b0;
        idle();
        wb_read(4'hC, d);
        chk("same_edge_levels", d, 8'h23);
        chk("tx_head_after", tx_data_o, 8'h52);

        // Soft reset with both FIFOs occupied
        wb_write(4'h0, 8'h03);
        wb_read(4'h0, d);
        chk("srst_control", d, 8'h00);
        wb_read(4'h4, d);
        chk("srst_status", d, 8'h0C);
        chk("srst_tx_valid", tx_valid_o, 0);

        // Hard reset at the same edge as an accepted read, strobe held
        wb_write(4'h0, 8'h0D);
        s_rvld = 1'b1; s_rdat = 8'h99;
        idle();
        s_rvld = 1'b0;
        wb_write(4'h8, 8'h77);
        s_rst = 1'b1;
        step(1'b1, 4'h8, 1'b0, 8'h00);
        s_rst = 1'b0;
        chk("rst_ack", wb_ack_o, 0);
        chk("rst_rdata", wb_dat_o, 8'h00);
        chk("rst_irq", irq_o, 0);
        idle();
        wb_read(4'h4, d);
        chk("rst_status", d, 8'h0C);
        wb_read(4'hC, d);
        chk("rst_level", d, 8'h00);

        // Randomized traffic with phase-biased stream rates
        for (int i = 0; i < 3000; i++) begin
            logic       act, we;
            logic [3:0] adr;
            logic [7:0] dat;
            int         phase;
            phase  = (i / 300) % 3;
            act    = 1'($urandom_range(0, 1));
            adr    = {2'($urandom_range(0, 3)), 2'b00};
            we     = 1'($urandom_range(0, 1));
            dat    = 8'($urandom);
            if (adr == 4'h0 && we) begin
                dat[0] = ($urandom_range(0, 3) != 0);
                dat[1] = ($urandom_range(0, 15) == 0);
            end
            s_trdy = (phase == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
            s_rvld = (phase == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            s_rdat = 8'($urandom);
            s_rst  = ($urandom_range(0, 599) == 0);
            step(act, adr, we, dat);
        end
        s_rst = 1'b0; s_trdy = 1'b0; s_rvld = 1'b0;
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
